port_rd_frontend: RTL and testbench

Per-port read sequencer downstream of the port read dispatcher. It samples the dispatcher's chosen queue (`prior_next`) once that choice has settled, and issues a packet read request to the read engine. It waits for the packet to complete, then pulses `prior_update` so the dispatcher advances its WRR or strict-priority state. One instance sits between each port's dispatcher and the shared read engine.

---
 rtl/port_rd_frontend.sv | 166 ++++++++++++++++
 tb/tb_port_rd_frontend.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_rd_frontend.sv
// port_rd_frontend: per-port read sequencer between dispatcher and read engine.
// Define PORT_RD_STAT_EN to build the per-queue packet counters and stat_cnt mux.
module port_rd_frontend #(
   parameter int unsigned SETTLE_CYC = 6,
   parameter int unsigned TIMEOUT    = 1023,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       prior_next,
   input  logic [7:0]       queue_empty,
   input  logic             port_ready,
   output logic             prior_update,
   output logic             rd_req,
   output logic [2:0]       rd_queue,
   input  logic             rd_ack,
   input  logic             rd_done,
   output logic             rd_err,
   output logic             busy,
   input  logic [2:0]       stat_sel,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_cnt
);

   localparam int SCW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
   localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [SCW-1:0] SETTLE_LD = SCW'(SETTLE_CYC);
   localparam logic [WDW-1:0] WD_LD     = WDW'(TIMEOUT);
   localparam bit             WD_EN     = (TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_UPDATE,
      S_SETTLE
   } state_t;

   state_t         state_q, state_d;
   logic [SCW-1:0] set_q, set_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic [2:0]     q_q, q_d;
   logic           req_q, req_d;
   logic           pu_q, pu_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
   logic           go;

   assign go = port_ready & ~prior_next[3] & ~queue_empty[prior_next[2:0]];

   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      wd_d    = wd_q;
      q_d     = q_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_SETTLE: begin
            if (set_q == '0) state_d = S_IDLE;
            else             set_d   = set_q - SCW'(1);
         end
         S_IDLE: begin
            if (go) begin
               q_d     = prior_next[2:0];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // an ack in the same cycle as the queue draining still wins
            if (rd_ack) begin
               state_d = S_WAIT;
               wd_d    = WD_LD;
            end else if (queue_empty[q_q]) begin
               state_d = S_SETTLE;
               set_d   = SETTLE_LD;
            end
         end
         S_WAIT: begin
            if (rd_done) begin
               state_d = S_UPDATE;
            end else if (WD_EN && wd_q == WDW'(1)) begin
               state_d = S_UPDATE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q - WDW'(1);
            end
         end
         S_UPDATE: begin
            state_d = S_SETTLE;
            set_d   = SETTLE_LD;
         end
         default: begin
            state_d = S_SETTLE;
            set_d   = SETTLE_LD;
         end
      endcase
      req_d  = (state_d == S_ISSUE);
      pu_d   = (state_d == S_UPDATE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_SETTLE;
         set_q   <= SETTLE_LD;
         wd_q    <= '0;
         q_q     <= '0;
         req_q   <= 1'b0;
         pu_q    <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         wd_q    <= wd_d;
         q_q     <= q_d;
         req_q   <= req_d;
         pu_q    <= pu_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign rd_req       = req_q;
   assign rd_queue     = q_q;
   assign prior_update = pu_q;
   assign rd_err       = err_q;
   assign busy         = busy_q;

`ifdef PORT_RD_STAT_EN
   logic [CNT_W-1:0] cnt_q [8];
   logic [CNT_W-1:0] cnt_d [8];
   logic [CNT_W-1:0] stat_q, stat_d;
   logic             cnt_inc;

   // err_q is high exactly in an UPDATE reached by watchdog expiry
   assign cnt_inc = (state_q == S_UPDATE) & ~err_q;

   always_comb begin
      for (int i = 0; i < 8; i++) cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
         for (int i = 0; i < 8; i++) cnt_d[i] = '0;
      end else if (cnt_inc && cnt_q[q_q] != '1) begin
         cnt_d[q_q] = cnt_q[q_q] + CNT_W'(1);
      end
      stat_d = cnt_q[stat_sel];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
         stat_q <= '0;
      end else begin
         for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
         stat_q <= stat_d;
      end
   end

   assign stat_cnt = stat_q;
`else
   logic unused_stat;
   assign unused_stat = ^{stat_sel, stat_clr};
   assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_port_rd_frontend.sv
// tb_port_rd_frontend: directed + randomized bench for port_rd_frontend with a
// sequential (thread-style) reference model of the packet read sequence.
module tb_port_rd_frontend;

   localparam int SETTLE = 6;
   localparam int TMO    = 12;
   localparam int CW     = 2;
   localparam int CMAX   = (1 << CW) - 1;
`ifdef PORT_RD_STAT_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    prior_next = 4'd2;
   logic [7:0]    queue_empty = 8'hFB;
   logic          port_ready = 1'b1;
   logic          prior_update;
   logic          rd_req;
   logic [2:0]    rd_queue;
   logic          rd_ack = 1'b0;
   logic          rd_done = 1'b0;
   logic          rd_err;
   logic          busy;
   logic [2:0]    stat_sel = 3'd2;
   logic          stat_clr = 1'b0;
   logic [CW-1:0] stat_cnt;

   port_rd_frontend #(
      .SETTLE_CYC(SETTLE),
      .TIMEOUT   (TMO),
      .CNT_W     (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .prior_next  (prior_next),
      .queue_empty (queue_empty),
      .port_ready  (port_ready),
      .prior_update(prior_update),
      .rd_req      (rd_req),
      .rd_queue    (rd_queue),
      .rd_ack      (rd_ack),
      .rd_done     (rd_done),
      .rd_err      (rd_err),
      .busy        (busy),
      .stat_sel    (stat_sel),
      .stat_clr    (stat_clr),
      .stat_cnt    (stat_cnt)
   );

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit exp_pu, exp_req, exp_err, exp_busy;
   int exp_q, exp_stat;
   int cnt_m [8];
   bit inc_pend;
   int inc_q;
   bit abort;

   task automatic reset_exp();
      exp_pu   = 1'b0;
      exp_req  = 1'b0;
      exp_err  = 1'b0;
      exp_busy = 1'b1;
      exp_q    = 0;
      exp_stat = 0;
      inc_pend = 1'b0;
      for (int i = 0; i < 8; i++) cnt_m[i] = 0;
   endtask

   // one clock edge: counters and the stat readback follow the edge
   task automatic step();
      @(posedge clk or posedge rst);
      if (rst) begin
         abort = 1'b1;
         reset_exp();
         return;
      end
      exp_stat = STAT_EN ? cnt_m[stat_sel] : 0;
      if (stat_clr) begin
         for (int i = 0; i < 8; i++) cnt_m[i] = 0;
      end else if (inc_pend && cnt_m[inc_q] < CMAX) begin
         cnt_m[inc_q]++;
      end
      inc_pend = 1'b0;
   endtask

   // one pass per packet attempt, starting in the first settle cycle
   task automatic run_packets();
      int q, n;
      bit fin, err, ab;
      forever begin
         repeat (SETTLE) begin
            step();
            if (abort) return;
         end
         step();
         if (abort) return;
         exp_busy = 1'b0;
         forever begin
            step();
            if (abort) return;
            if (port_ready && !prior_next[3] && !queue_empty[prior_next[2:0]])
               break;
         end
         q        = int'(prior_next[2:0]);
         exp_req  = 1'b1;
         exp_q    = q;
         exp_busy = 1'b1;
         ab  = 1'b0;
         fin = 1'b0;
         while (!fin) begin
            step();
            if (abort) return;
            if (rd_ack) begin
               fin = 1'b1;
            end else if (queue_empty[q]) begin
               ab  = 1'b1;
               fin = 1'b1;
            end
         end
         exp_req = 1'b0;
         if (ab) continue;
         n   = 0;
         fin = 1'b0;
         err = 1'b0;
         while (!fin) begin
            step();
            if (abort) return;
            n++;
            if (rd_done) begin
               fin = 1'b1;
            end else if (n == TMO) begin
               err = 1'b1;
               fin = 1'b1;
            end
         end
         exp_pu   = 1'b1;
         exp_err  = err;
         inc_pend = !err;
         inc_q    = q;
         step();
         if (abort) return;
         exp_pu  = 1'b0;
         exp_err = 1'b0;
      end
   endtask

   initial begin : model
      forever begin
         reset_exp();
         abort = 1'b0;
         wait (rst == 1'b0);
         run_packets();
      end
   end

   always @(negedge clk) begin
      chk("prior_update", int'(prior_update), int'(exp_pu));
      chk("rd_req", int'(rd_req), int'(exp_req));
      chk("rd_queue", int'(rd_queue), exp_q);
      chk("rd_err", int'(rd_err), int'(exp_err));
      chk("busy", int'(busy), int'(exp_busy));
      chk("stat_cnt", int'(stat_cnt), exp_stat);
   end

   // ---------------- stimulus ----------------
   int e0, ack_e, np, nb, bad;
   bit ok;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_req(output bit got);
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (rd_req) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      if (!got) begin
         n_vec++;
         n_bad++;
         $display("FAIL req_wait: rd_req never rose within 60 cycles");
      end
   endtask

   task automatic do_pkt(input int ad, input int dd);
      bit got;
      wait_req(got);
      if (!got) return;
      repeat (ad) tick();
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      repeat (dd) tick();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_busy", int'(busy), 1);
      chk("rst_req", int'(rd_req), 0);
      chk("rst_stat", int'(stat_cnt), 0);

      // post-reset settle: 7 settle cycles, decision on the 8th edge
      rst = 1'b0;
      e0  = ecnt;
      wait_req(ok);
      chk("first_req_edge", ecnt - e0, 8);
      chk("first_rd_queue", int'(rd_queue), 2);

      // normal packet on queue 2
      do_pkt(3, 4);
      port_ready = 1'b0;
      chk("pu_after_done", int'(prior_update), 1);
      np = 0;
      for (int i = 0; i < 12; i++) begin
         if (prior_update) np++;
         tick();
      end
      chk("pu_pulses", np, 1);
      chk("stat_q2_one", int'(stat_cnt), STAT_EN ? 1 : 0);

      // abort while issuing
      port_ready = 1'b1;
      wait_req(ok);
      tick();
      queue_empty = 8'hFF;
      port_ready  = 1'b0;
      tick();
      chk("abort_req_drop", int'(rd_req), 0);
      nb = 0;
      np = 0;
      for (int i = 0; i < 12; i++) begin
         if (prior_update) np++;
         if (busy && nb == i) nb++;
         tick();
      end
      chk("abort_busy_cyc", nb, 7);
      chk("abort_no_pu", np, 0);
      chk("abort_stat", int'(stat_cnt), STAT_EN ? 1 : 0);
      queue_empty = 8'hFB;

      // watchdog expiry
      port_ready = 1'b1;
      wait_req(ok);
      port_ready = 1'b0;
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      ack_e  = ecnt;
      for (int i = 0; i < 30; i++) begin
         if (rd_err) break;
         tick();
      end
      chk("wdog_latency", ecnt - ack_e, TMO);
      chk("wdog_pu", int'(prior_update), 1);
      repeat (3) tick();
      chk("wdog_stat", int'(stat_cnt), STAT_EN ? 1 : 0);

      // no readable queue, then back-pressure
      prior_next = 4'd8;
      port_ready = 1'b1;
      repeat (12) tick();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (rd_req || busy) bad++;
         tick();
      end
      chk("noq_idle", bad, 0);
      prior_next = 4'd2;
      port_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (rd_req || busy) bad++;
         tick();
      end
      chk("bp_idle", bad, 0);

      // saturation on queue 0, then clear colliding with an update
      prior_next  = 4'd0;
      queue_empty = 8'hFE;
      port_ready  = 1'b1;
      stat_sel    = 3'd0;
      for (int k = 0; k < 5; k++)
         do_pkt($urandom_range(0, 2), $urandom_range(0, 3));
      repeat (3) tick();
      chk("sat_q0", int'(stat_cnt), STAT_EN ? 3 : 0);
      do_pkt(0, 0);
      stat_clr = 1'b1;
      tick();
      stat_clr   = 1'b0;
      port_ready = 1'b0;
      repeat (2) tick();
      chk("clr_q0", int'(stat_cnt), 0);
      stat_sel = 3'd2;
      repeat (2) tick();
      chk("clr_q2", int'(stat_cnt), 0);

      // randomized traffic with two mid-run resets
      for (int i = 0; i < 4000; i++) begin
         if (i == 1500 || i == 2900) begin
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
         end
         if ($urandom_range(0, 4) == 0)
            prior_next = 4'(8 + $urandom_range(0, 7));
         else
            prior_next = 4'($urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0)
            queue_empty = 8'($urandom & $urandom);
         port_ready = ($urandom_range(0, 3) != 0);
         rd_ack     = ($urandom_range(0, 2) == 0);
         rd_done    = ($urandom_range(0, 5) == 0);
         stat_clr   = ($urandom_range(0, 60) == 0);
         stat_sel   = 3'($urandom_range(0, 7));
         tick();
      end
      rd_ack  = 1'b0;
      rd_done = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
